fetch_redirect_ctrl: RTL and testbench

Owns the fetch program counter and consumes the execute-stage branch decision. On a taken branch or jump resolved in EX, it redirects the PC to the target, squashes the two wrong-path instructions in IF/ID and ID/EX, and counts redirects. A misaligned target halts fetch until reset. The block sits between the EX branch-decision logic, the hazard unit (stall) and the instruction memory address port.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_redirect_ctrl.sv | 94 +++++++++
 tb/tb_fetch_redirect_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared fetch/hazard definitions: reset PC, instruction size and the
// fetch FSM state encoding.
package fetch_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0100_0000;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value; sticks at all-ones, never wraps
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner. Takes the EX-stage branch/jump decision, redirects the PC,
// squashes the two wrong-path slots (IF/ID, ID/EX) and counts redirects.
// A misaligned redirect target parks the block in HALT until reset.
//   clock, reset        : clock and synchronous active-high reset
//   stall               : hazard-unit freeze of PC and IF/ID
//   ex_valid, br_tk,
//   jump, ex_target     : EX branch decision and final target
//   pc, pc_valid        : registered fetch address and its valid
//   flush_if_id/id_ex   : same-cycle squash of the wrong-path slots
//   misalign_err        : one-cycle pulse on a misaligned redirect
//   halted              : block is in HALT
//   redirect_cnt        : saturating count of accepted redirects
module fetch_redirect_ctrl #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(32'h0100_0000),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             br_tk,
    input  logic             jump,
    input  logic [XLEN-1:0]  ex_target,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    import fetch_redirect_ctrl_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redir_req;
    logic            misaligned;
    logic            flush;
    logic            cnt_inc;

    assign redir_req  = ex_valid & (br_tk | jump);
    assign misaligned = (ex_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The reset guard keeps every combinational output low while reset is high.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush        = 1'b0;
        misalign_err = 1'b0;
        cnt_inc      = 1'b0;
        if (!reset && (state_q == RUN)) begin
            if (redir_req && misaligned) begin
                misalign_err = 1'b1;
                flush        = 1'b1;
                state_d      = HALT;
            end else if (redir_req) begin
                // Redirect beats stall: the stalled slot is wrong-path anyway.
                pc_d    = ex_target;
                flush   = 1'b1;
                cnt_inc = 1'b1;
            end else if (!stall) begin
                pc_d = pc_q + XLEN'(INSN_BYTES);
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_redirect_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cnt_inc),
        .count (redirect_cnt)
    );

    assign pc          = pc_q;
    assign pc_valid    = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign flush_if_id = flush;
    assign flush_id_ex = flush;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset, stall, ex_valid, br_tk, jump;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        pc_valid, flush_if_id, flush_id_ex, misalign_err, halted;
    logic [15:0] redirect_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    int unsigned m_cnt;

    always #5 clock = ~clock;

    fetch_redirect_ctrl #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .CNT_W    (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .br_tk        (br_tk),
        .jump         (jump),
        .ex_target    (ex_target),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .misalign_err (misalign_err),
        .halted       (halted),
        .redirect_cnt (redirect_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check same-cycle outputs, clock, check state.
    task automatic cycle(input bit rst, input bit st, input bit ev, input bit bt,
                         input bit jp, input logic [31:0] tgt);
        bit req, mis, exp_flush, exp_merr;
        reset = rst; stall = st; ex_valid = ev; br_tk = bt; jump = jp; ex_target = tgt;
        #1;
        req       = ev && (bt || jp);
        mis       = (tgt % 4) != 0;
        exp_flush = !rst && !m_halt && req;
        exp_merr  = exp_flush && mis;
        chk("flush_if_id",  {31'b0, flush_if_id},  {31'b0, exp_flush});
        chk("flush_id_ex",  {31'b0, flush_id_ex},  {31'b0, exp_flush});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_merr});
        @(posedge clock);
        if (rst) begin
            m_pc = RST_PC; m_halt = 0; m_cnt = 0;
        end else if (!m_halt) begin
            if (req && mis)      m_halt = 1;
            else if (req) begin
                m_pc = tgt;
                if (m_cnt < 65535) m_cnt++;
            end else if (!st)    m_pc = m_pc + 32'd4;
        end
        #1;
        chk("pc",           pc,                     m_pc);
        chk("pc_valid",     {31'b0, pc_valid},      {31'b0, !m_halt});
        chk("halted",       {31'b0, halted},        {31'b0, m_halt});
        chk("redirect_cnt", {16'b0, redirect_cnt},  m_cnt);
    endtask

    task automatic idle(input bit st);
        cycle(0, st, 0, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] t;
        m_pc = 32'hx; m_halt = 0; m_cnt = 0;
        reset = 1; stall = 0; ex_valid = 0; br_tk = 0; jump = 0; ex_target = '0;

        // Reset, including a redirect request that reset must override
        cycle(1, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 1, 1, 0, 32'h0100_0200);

        // Sequential fetch
        idle(0); idle(0); idle(0); idle(0);          // pc now 0x0100_0010
        cycle(0, 0, 1, 1, 0, 32'h0100_0200);         // taken branch
        cycle(0, 0, 1, 0, 1, 32'h0100_0020);         // jump to 0x20 (cnt 2)
        // Stall two cycles, jump on the second: redirect wins over stall
        idle(1);
        cycle(0, 1, 1, 0, 1, 32'h0100_0400);
        // Branch without ex_valid is ignored
        cycle(0, 0, 0, 1, 0, 32'h0100_0800);
        cycle(0, 0, 0, 0, 1, 32'h0100_0800);
        // Back-to-back redirects, later one wins
        cycle(0, 0, 1, 1, 0, 32'h0200_0000);
        cycle(0, 0, 1, 1, 0, 32'h0300_0000);
        // Misaligned target halts; later redirects ignored
        cycle(0, 0, 1, 1, 0, 32'h0100_0102);
        cycle(0, 0, 1, 1, 0, 32'h0100_0300);
        cycle(0, 0, 1, 0, 1, 32'h0100_0301);
        idle(0);
        // Reset out of HALT
        cycle(1, 0, 0, 0, 0, 32'h0);
        idle(0);
        // PC wraps modulo 2^32
        cycle(0, 0, 1, 0, 1, 32'hFFFF_FFF8);
        idle(0); idle(0); idle(0);

        // Counter saturation
        cycle(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 65540; i++) begin
            t = $urandom & 32'hFFFF_FFFC;
            cycle(0, ($urandom % 2) == 0, 1, 1, ($urandom % 2) == 0, t);
        end
        idle(0);
        cycle(0, 0, 1, 1, 0, 32'h0100_0000);

        // Randomized mix against the reference model
        cycle(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 1500; i++) begin
            bit rst;
            rst = ($urandom % 60) == 0;
            t = $urandom;
            if (($urandom % 8) != 0) t = t & 32'hFFFF_FFFC;
            if (($urandom % 10) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
            cycle(rst, ($urandom % 4) == 0, ($urandom % 3) != 0,
                  ($urandom % 4) == 0, ($urandom % 6) == 0, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
